// File: rtl/sobel_edge_window.sv
// Streaming 3x3 Sobel edge stage: two line RAMs, a 3x3 window and a 3-stage stall-all pipeline.
// Optional binarisation of the output is enabled by defining SOBEL_THRESH_EN.
module sobel_edge_window #(
  parameter int IMG_W = 1280,
  parameter int IMG_H = 720,
  parameter int CNT_W = 12,
  parameter int SHIFT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       fifo_rd_vld,
  input  logic [7:0] fifo_rd_data,
  output logic       fifo_rd_en,
  input  logic [7:0] thresh,
  input  logic       out_rdy,
  output logic       out_vld,
  output logic [7:0] out_data,
  output logic       out_sof,
  output logic       out_eol
);

  localparam int AW = $clog2(IMG_W);
  localparam logic [CNT_W-1:0] X_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] TWO    = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  // Handshake: a pixel is taken when fifo_rd_en & fifo_rd_vld; a beat leaves when out_vld & out_rdy.
  // The whole pipeline advances only when en (output register empty or being drained) is high.
  logic en, accept;
  logic armed_q, armed_d;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d, x_cur, y_cur;

  logic       col_vld_q, col_vld_d;
  logic       prod_s0_q, prod_s0_d;
  logic       sof_s0_q, sof_s0_d;
  logic       eol_s0_q, eol_s0_d;
  logic [7:0] pix_q, pix_d;
  logic       wb_vld_q, wb_vld_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;

  logic [7:0] w_q [3][3];
  logic [7:0] w_d [3][3];
  logic       s1_vld_q, s1_vld_d;
  logic       sof_s1_q, sof_s1_d;
  logic       eol_s1_q, eol_s1_d;

  logic       out_vld_q, out_vld_d;
  logic [7:0] out_data_q, out_data_d;
  logic       out_sof_q, out_sof_d;
  logic       out_eol_q, out_eol_d;

  logic [7:0] lb0_mem [IMG_W];
  logic [7:0] lb1_mem [IMG_W];
  logic [7:0] lb0_rd_q, lb1_rd_q;
  logic [AW-1:0] addr;

  // Not reset until a frame_start arrives, so a reset mid-frame stops popping until then.
  assign en         = ~out_vld_q | out_rdy;
  assign fifo_rd_en = en & (armed_q | frame_start);
  assign accept     = fifo_rd_en & fifo_rd_vld;
  assign x_cur      = frame_start ? '0 : x_q;
  assign y_cur      = frame_start ? '0 : y_q;
  assign addr       = x_cur[AW-1:0];

  always_comb begin
    armed_d = armed_q | frame_start;
    x_d     = x_cur;
    y_d     = y_cur;
    if (accept) begin
      if (x_cur == X_LAST) begin
        x_d = '0;
        y_d = (y_cur == Y_LAST) ? '0 : y_cur + ONE;
      end else begin
        x_d = x_cur + ONE;
      end
    end
  end

  // S0: pixel register and sync-read line RAM outputs; lb1 is written one cycle late from lb0's read.
  always_comb begin
    col_vld_d = col_vld_q;
    prod_s0_d = prod_s0_q;
    sof_s0_d  = sof_s0_q;
    eol_s0_d  = eol_s0_q;
    pix_d     = pix_q;
    wb_vld_d  = accept;
    wb_addr_d = accept ? addr : wb_addr_q;
    if (frame_start) begin
      col_vld_d = 1'b0;
      prod_s0_d = 1'b0;
    end
    if (en) begin
      col_vld_d = accept;
      prod_s0_d = accept && (x_cur >= TWO) && (y_cur >= TWO);
      sof_s0_d  = (x_cur == TWO) && (y_cur == TWO);
      eol_s0_d  = (x_cur == X_LAST);
    end
    if (accept) pix_d = fifo_rd_data;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_rd_q      <= lb0_mem[addr];
      lb1_rd_q      <= lb1_mem[addr];
      lb0_mem[addr] <= fifo_rd_data;
    end
    if (wb_vld_q) lb1_mem[wb_addr_q] <= lb0_rd_q;
  end

  // S1: window shifts only on accepted columns; row 0 is the oldest line.
  always_comb begin
    w_d      = w_q;
    s1_vld_d = s1_vld_q;
    sof_s1_d = sof_s1_q;
    eol_s1_d = eol_s1_q;
    if (en) begin
      if (col_vld_q) begin
        for (int r = 0; r < 3; r++) begin
          w_d[r][0] = w_q[r][1];
          w_d[r][1] = w_q[r][2];
        end
        w_d[0][2] = lb1_rd_q;
        w_d[1][2] = lb0_rd_q;
        w_d[2][2] = pix_q;
      end
      s1_vld_d = prod_s0_q;
      sof_s1_d = sof_s0_q;
      eol_s1_d = eol_s0_q;
    end
    if (frame_start) s1_vld_d = 1'b0;
  end

  logic signed [10:0] e [3][3];
  logic signed [10:0] gx, gy;
  logic [10:0] gx_abs, gy_abs, mag, mag_sh;
  logic [7:0]  sat, res;

  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        e[r][c] = signed'({3'b000, w_q[r][c]});
    gx = (e[0][2] + (e[1][2] <<< 1) + e[2][2]) - (e[0][0] + (e[1][0] <<< 1) + e[2][0]);
    gy = (e[2][0] + (e[2][1] <<< 1) + e[2][2]) - (e[0][0] + (e[0][1] <<< 1) + e[0][2]);
    gx_abs = gx[10] ? $unsigned(-gx) : $unsigned(gx);
    gy_abs = gy[10] ? $unsigned(-gy) : $unsigned(gy);
    mag    = gx_abs + gy_abs;
    mag_sh = mag >> SHIFT;
    sat    = (|mag_sh[10:8]) ? 8'hFF : mag_sh[7:0];
  end

`ifdef SOBEL_THRESH_EN
  assign res = (sat >= thresh) ? 8'd255 : 8'd0;
`else
  assign res = sat;
  logic unused_thresh;
  assign unused_thresh = ^thresh;
`endif

  // S2: output register holds its beat until the consumer takes it.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_sof_d  = out_sof_q;
    out_eol_d  = out_eol_q;
    if (en) begin
      out_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        out_data_d = res;
        out_sof_d  = sof_s1_q;
        out_eol_d  = eol_s1_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      col_vld_q  <= 1'b0;
      prod_s0_q  <= 1'b0;
      sof_s0_q   <= 1'b0;
      eol_s0_q   <= 1'b0;
      pix_q      <= '0;
      wb_vld_q   <= 1'b0;
      wb_addr_q  <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          w_q[r][c] <= '0;
      s1_vld_q   <= 1'b0;
      sof_s1_q   <= 1'b0;
      eol_s1_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_sof_q  <= 1'b0;
      out_eol_q  <= 1'b0;
    end else begin
      armed_q    <= armed_d;
      x_q        <= x_d;
      y_q        <= y_d;
      col_vld_q  <= col_vld_d;
      prod_s0_q  <= prod_s0_d;
      sof_s0_q   <= sof_s0_d;
      eol_s0_q   <= eol_s0_d;
      pix_q      <= pix_d;
      wb_vld_q   <= wb_vld_d;
      wb_addr_q  <= wb_addr_d;
      w_q        <= w_d;
      s1_vld_q   <= s1_vld_d;
      sof_s1_q   <= sof_s1_d;
      eol_s1_q   <= eol_s1_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_sof_q  <= out_sof_d;
      out_eol_q  <= out_eol_d;
    end
  end

  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;
  assign out_sof  = out_sof_q;
  assign out_eol  = out_eol_q;

endmodule

// File: tb/tb_sobel_edge_window.sv
// Bench for sobel_edge_window on an 8x6 frame: directed frames, expected beats queued at issue,
// a negedge monitor pops and compares {sof,eol,data} per output handshake.
module tb_sobel_edge_window;
  localparam int W = 8;
  localparam int H = 6;
`ifdef SOBEL_THRESH_EN
  localparam logic [7:0] DOT_EXP = 8'd255;
`else
  localparam logic [7:0] DOT_EXP = 8'd80;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       frame_start = 1'b0;
  logic       fifo_rd_vld = 1'b0;
  logic [7:0] fifo_rd_data = 8'd0;
  logic       fifo_rd_en;
  logic [7:0] thresh = 8'd80;
  logic       out_rdy;
  logic       out_vld;
  logic [7:0] out_data;
  logic       out_sof;
  logic       out_eol;

  int n_tests = 0;
  int n_fail  = 0;
  logic [9:0] exp_q[$];
  int rdy_mode = 0;
  int gap_en   = 0;
  int rdy_cnt  = 0;

  sobel_edge_window #(.IMG_W(W), .IMG_H(H), .CNT_W(12), .SHIFT(0)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .fifo_rd_vld(fifo_rd_vld), .fifo_rd_data(fifo_rd_data), .fifo_rd_en(fifo_rd_en),
    .thresh(thresh), .out_rdy(out_rdy), .out_vld(out_vld), .out_data(out_data),
    .out_sof(out_sof), .out_eol(out_eol)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // ready pattern: 0 always ready, 1 ready one cycle in three, 2 never ready
  always @(posedge clk) begin
    #1;
    rdy_cnt++;
    out_rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? ((rdy_cnt % 3) == 0) : 1'b0;
  end

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] pix_val(input int pat, input int e, input int x, input int y);
    case (pat)
      0:       return 8'd100;
      1:       return (x >= e) ? 8'd255 : 8'd0;
      default: return (x == 3 && y == 3) ? 8'd40 : 8'd0;
    endcase
  endfunction

  // Hand-derived results: a 0->255 step at column e gives Gx=1020 at centres e-1 and e;
  // a lone 40 at (3,3) gives magnitude 80 at its eight neighbours and 0 at its centre.
  function automatic logic [9:0] exp_word(input int pat, input int e, input int cx, input int cy);
    logic [7:0] d;
    d = 8'd0;
    if (pat == 1 && (cx == e - 1 || cx == e)) d = 8'd255;
    if (pat == 2 && cx >= 2 && cx <= 4 && cy >= 2 && cy <= 4 && !(cx == 3 && cy == 3)) d = DOT_EXP;
    return {logic'(cx == 1 && cy == 1), logic'(cx == W - 2), d};
  endfunction

  // scoreboard monitor, sampling at negedge
  logic [9:0] held = '0;
  bit stalled = 0;
  always @(negedge clk) begin
    logic [9:0] exp_w;
    if (!rst_n) begin
      stalled = 0;
    end else begin
      if (stalled) begin
        check("stall_vld", int'(out_vld), 1);
        check("stall_word", int'({out_sof, out_eol, out_data}), int'(held));
      end
      if (out_vld && !out_rdy) check("no_pop_stall", int'(fifo_rd_en), 0);
      if (out_vld && out_rdy) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL extra_beat: got 0x%0h, expected no beat", {out_sof, out_eol, out_data});
        end else begin
          exp_w = exp_q.pop_front();
          check("beat", int'({out_sof, out_eol, out_data}), int'(exp_w));
        end
      end
      stalled = out_vld && !out_rdy;
      held = {out_sof, out_eol, out_data};
    end
  end

  // driver tasks; all return at posedge+1
  task automatic push_pix(input logic [7:0] p);
    int budget;
    if (gap_en != 0) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    fifo_rd_vld  = 1'b1;
    fifo_rd_data = p;
    budget = 0;
    forever begin
      @(negedge clk);
      if (fifo_rd_en) break;
      budget++;
      if (budget > 300) begin
        n_tests++;
        n_fail++;
        $display("FAIL pop_timeout: got no fifo_rd_en, expected a pop within 300 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    fifo_rd_vld = 1'b0;
  endtask

  task automatic send_frame(input int pat, input int e, input int n_pix);
    for (int cy = 1; cy <= H - 2; cy++)
      for (int cx = 1; cx <= W - 2; cx++)
        if ((cy + 1) * W + cx + 1 < n_pix) exp_q.push_back(exp_word(pat, e, cx, cy));
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    for (int i = 0; i < n_pix; i++) push_pix(pix_val(pat, e, i % W, i / W));
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 400) begin
      @(posedge clk);
      budget++;
    end
    repeat (8) @(posedge clk);
    #1;
    check({name, "_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_vld", int'(out_vld), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_sof", int'(out_sof), 0);
    check("rst_out_eol", int'(out_eol), 0);
    check("rst_rd_en", int'(fifo_rd_en), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("unarmed_rd_en", int'(fifo_rd_en), 0);
    @(posedge clk); #1;

    send_frame(0, 0, W * H);
    drain("t1_flat");

    send_frame(1, 4, W * H);
    drain("t2_step");

    rdy_mode = 1;
    gap_en   = 1;
    send_frame(1, 4, W * H);
    drain("t3_stall");
    rdy_mode = 0;
    gap_en   = 0;

    send_frame(1, 2, 20);
    repeat (10) @(posedge clk);
    #1;
    drain("t4_partial");
    send_frame(1, 4, W * H);
    drain("t4_full");

    rdy_mode = 2;
    send_frame(1, 2, 19);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("t5_held_vld", int'(out_vld), 1);
    check("t5_held_data", int'(out_data), 255);
    check("t5_held_sof", int'(out_sof), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_vld", int'(out_vld), 0);
    check("t5_rst_data", int'(out_data), 0);
    check("t5_rst_sof", int'(out_sof), 0);
    check("t5_rst_eol", int'(out_eol), 0);
    check("t5_rst_rd_en", int'(fifo_rd_en), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    send_frame(1, 6, W * H);
    drain("t5_after_rst");

    send_frame(2, 0, W * H);
    drain("t6_dot");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
